// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master driver and its shift registers.
package spi_pkg;

  localparam int DEF_ADDR_SIZE     = 8;
  localparam int DEF_RD_TURNAROUND = 2;

  typedef enum logic [2:0] {
    M_IDLE,
    M_CMD,
    M_SHIFT,
    M_TURN,
    M_CAPTURE,
    M_END
  } master_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shreg.sv
// Parallel-load, MSB-first shift register with serial input; load wins over shift.
module spi_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (load)
      q <= load_val;
    else if (shift)
      q <= {q[W-2:0], sin};
  end

endmodule

// File: rtl/spi_master_drv.sv
// SPI master stimulus stage: frames {cmd,payload} MSB-first on MOSI under SS_n and,
// for rd-data commands, captures the slave's reply byte from MISO.
module spi_master_drv
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE     = DEF_ADDR_SIZE,
  parameter int RD_TURNAROUND = DEF_RD_TURNAROUND
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           cmd,
  input  logic [ADDR_SIZE-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] rd_data,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int FRAME_W = ADDR_SIZE + 2;
  localparam int CNT_W   = ($clog2(FRAME_W) > 4) ? $clog2(FRAME_W) : 4;
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(RD_TURNAROUND - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(ADDR_SIZE - 1);

  master_state_e          state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             cmd_q;
  logic [ADDR_SIZE-1:0]   rd_q;
  logic [FRAME_W-1:0]     tx_q;
  logic [ADDR_SIZE-1:0]   rx_q;
  logic                   accept;
  logic                   tx_unused;

  assign accept = (state == M_IDLE) && start;
  // Only the MSB leaves the transmit register; the lower bits just feed the shift chain.
  assign tx_unused = ^tx_q[FRAME_W-2:0];

  spi_shreg #(.W(FRAME_W)) u_tx (
    .clk      (clk),
    .load     (accept),
    .load_val ({cmd, wdata}),
    .shift    (state == M_SHIFT),
    .sin      (1'b0),
    .q        (tx_q)
  );

  spi_shreg #(.W(ADDR_SIZE)) u_rx (
    .clk      (clk),
    .load     (1'b0),
    .load_val ('0),
    .shift    (state == M_CAPTURE),
    .sin      (MISO),
    .q        (rx_q)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= M_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      M_IDLE:    if (start) state_nxt = M_CMD;
      M_CMD:     state_nxt = M_SHIFT;
      M_SHIFT:   if (cnt == SHIFT_LAST)
                   state_nxt = (cmd_q == CMD_RD_DATA) ? M_TURN : M_END;
      M_TURN:    if (cnt == TURN_LAST) state_nxt = M_CAPTURE;
      M_CAPTURE: if (cnt == CAP_LAST) state_nxt = M_END;
      M_END:     state_nxt = M_IDLE;
      default:   state_nxt = M_IDLE;
    endcase
  end

  // Per-state bit counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      cmd_q <= CMD_WR_ADDR;
      rd_q  <= '0;
    end else begin
      if (state_nxt != state || state == M_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (accept)
        cmd_q <= cmd;
      if (state == M_END && cmd_q == CMD_RD_DATA)
        rd_q <= rx_q;
    end
  end

  always_comb begin
    SS_n    = 1'b1;
    MOSI    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    rd_data = rd_q;
    case (state)
      M_CMD: begin
        SS_n = 1'b0;
        MOSI = cmd_q[1];
        busy = 1'b1;
      end
      M_SHIFT: begin
        SS_n = 1'b0;
        MOSI = tx_q[FRAME_W-1];
        busy = 1'b1;
      end
      M_TURN, M_CAPTURE: begin
        SS_n = 1'b0;
        busy = 1'b1;
      end
      M_END: begin
        done = 1'b1;
        // The freshly captured byte is presented together with done.
        if (cmd_q == CMD_RD_DATA)
          rd_data = rx_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master_drv.sv
// Scoreboard bench for spi_master_drv: stimulus pushes hand-computed frame expectations,
// a monitor reassembles frames from the pins, plays a small slave/RAM model on MISO and checks.
module tb_spi_master_drv;

  localparam int RT   = 2;
  localparam int CAP0 = 11 + RT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, SS_n, MOSI;
  logic [7:0] rd_data;
  logic       MISO = 1'b1;

  spi_master_drv #(.ADDR_SIZE(8), .RD_TURNAROUND(RT)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cmd     (cmd),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] bits;
    int          low;
    int          done_cyc;
    logic [7:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

  logic [7:0] slave_mem [256];
  logic [7:0] s_addr = 8'h00;
  logic [7:0] s_rd_addr = 8'h00;
  bit         force_en = 1'b0;
  logic [7:0] force_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  bit          in_frame = 1'b0;
  bit          busy_bad = 1'b0;
  int          low_cnt = 0;
  int          started = 0;
  int          finished = 0;
  logic [10:0] bits = '0;

  always @(posedge clk) begin
    logic [7:0] reply;
    exp_t e;
    #1;
    cyc++;
    if (rst) begin
      in_frame = 1'b0;
      started  = finished;
      MISO     = 1'b1;
      chk("rst_ss_n", SS_n, 1);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_data", rd_data, 0);
    end else if (!SS_n) begin
      if (!in_frame) begin
        chk("done_before_fall", finished, started);
        in_frame = 1'b1;
        started++;
        low_cnt  = 0;
        bits     = '0;
        busy_bad = 1'b0;
      end
      if (low_cnt < 11) bits = {bits[9:0], MOSI};
      if (!busy) busy_bad = 1'b1;
      reply = force_en ? force_byte : slave_mem[s_rd_addr];
      if (bits[9:8] == 2'b11 && low_cnt >= CAP0 && low_cnt < CAP0 + 8)
        MISO = reply[7 - (low_cnt - CAP0)];
      else
        MISO = 1'b1;
      low_cnt++;
    end else begin
      MISO = 1'b1;
      if (done) begin
        finished++;
        if (!in_frame) begin
          n_vec++; n_miss++;
          $display("FAIL done_without_frame at cycle %0d", cyc);
        end else if (sb.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_done at cycle %0d, frame bits %0h", cyc, bits);
        end else begin
          e = sb.pop_front();
          chk("mosi_bits", bits, e.bits);
          chk("ss_low_cycles", low_cnt, e.low);
          chk("done_cycle", cyc, e.done_cyc);
          chk("busy_in_frame", busy_bad, 0);
          chk("busy_at_done", busy, 0);
          chk("rd_data", rd_data, e.rd);
        end
        case (bits[9:8])
          2'b00:   s_addr = bits[7:0];
          2'b01:   slave_mem[s_addr] = bits[7:0];
          2'b10:   s_rd_addr = bits[7:0];
          default: ;
        endcase
      end else if (in_frame) begin
        n_vec++; n_miss++;
        $display("FAIL ss_rise_without_done at cycle %0d", cyc);
      end
      in_frame = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int t = 0;
    while ((busy || done) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++; n_miss++;
      $display("FAIL idle_timeout: busy %0b done %0b after %0d cycles", busy, done, t);
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic [10:0] eb,
                       input int low, input logic [7:0] erd);
    exp_t e;
    wait_idle();
    cmd   = c;
    wdata = d;
    start = 1'b1;
    e.bits = eb; e.low = low; e.done_cyc = cyc + low + 1; e.rd = erd;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // wr-addr A5 and wr-data 3C with a start pulsed mid-frame
    issue(2'b00, 8'hA5, 11'b000_1010_0101, 11, 8'h00);
    issue(2'b01, 8'h3C, 11'b001_0011_1100, 11, 8'h00);
    repeat (3) @(negedge clk);
    cmd = 2'b10; wdata = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // read-back through the slave/RAM model
    issue(2'b00, 8'h10, 11'b000_0001_0000, 11, 8'h00);
    issue(2'b01, 8'h5A, 11'b001_0101_1010, 11, 8'h00);
    issue(2'b10, 8'h10, 11'b110_0001_0000, 11, 8'h00);
    issue(2'b11, 8'h00, 11'b111_0000_0000, 21, 8'h5A);

    // forced reply C3, then rd_data must hold across a write frame
    wait_idle();
    force_en = 1'b1; force_byte = 8'hC3;
    issue(2'b11, 8'hFF, 11'b111_1111_1111, 21, 8'hC3);
    wait_idle();
    force_en = 1'b0;
    issue(2'b00, 8'h81, 11'b000_1000_0001, 11, 8'hC3);

    // start held high: frames accepted only from IDLE
    wait_idle();
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      wait_idle();
      cmd   = 2'b01;
      wdata = 8'h11 << k;
      e.bits = {3'b001, 8'h11 << k}; e.low = 11; e.done_cyc = cyc + 12; e.rd = 8'hC3;
      sb.push_back(e);
      @(negedge clk);
    end
    start = 1'b0;

    // reset in the middle of SHIFT of a wr-addr frame
    wait_idle();
    cmd = 2'b00; wdata = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_in_frame", SS_n, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_reset_rd_data", rd_data, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
